// File: rtl/input_buff_defs.sv
// Shared definitions for the multi-channel serial capture buffer.
// Holds the capture FSM state encoding and the sample-index width helper
// used by both the top level and the per-channel capture slice.
package input_buff_defs;

  // Capture FSM: IDLE waits for start, CAPTURE takes one bit per channel per ena.
  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  // Width of the sample index: ceil(log2(n)), never narrower than one bit.
  function automatic int ndata_log(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/capture_chan.sv
// One channel of the serial capture buffer: shift-free bit capture plus frame hold register.
// Latency: a sample lands in the capture register on the ena edge; hold loads on the completion edge.
// Backpressure: none locally; the parent decides when the hold register may be overwritten.
//
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   init        reload capture register with the INIT pattern
//   sample      write bit_in into capture bit [idx]
//   idx         sample index of the bit being written
//   bit_in      serial data bit for this channel
//   load_hold   copy the frame (including a same-cycle sample) into the hold register
//   dout        held frame, bit i = sample i
module capture_chan
  import input_buff_defs::*;
#(
  parameter int   NDATA = 128,
  parameter logic INIT  = 1'b0,
  localparam int  IW    = ndata_log(NDATA)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             sample,
  input  logic [IW-1:0]    idx,
  input  logic             bit_in,
  input  logic             load_hold,
  output logic [NDATA-1:0] dout
);

  logic [NDATA-1:0] cap_q;
  logic [NDATA-1:0] hold_q;
  logic [NDATA-1:0] frame;

  // Frame as it will look after this edge's sample, so the final sample of a
  // frame reaches the hold register on the same edge it is captured.
  always_comb begin
    frame = cap_q;
    if (sample) begin
      frame[idx] = bit_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q  <= {NDATA{INIT}};
      hold_q <= {NDATA{INIT}};
    end else begin
      // init wins over sample: an abort or frame completion discards the bit.
      if (init) begin
        cap_q <= {NDATA{INIT}};
      end else if (sample) begin
        cap_q <= frame;
      end
      if (load_hold) begin
        hold_q <= frame;
      end
    end
  end

  assign dout = hold_q;

endmodule

// File: rtl/multi_input_buff.sv
// Multi-channel serial capture buffer: NCH serial inputs captured NDATA bits deep into a held frame.
// Latency: dout_valid rises one cycle after the final sample of a frame.
// Backpressure: valid/ready on dout; a frame completing while dout is unconsumed is dropped and flags overrun.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start         begin (or restart) a frame capture
//   cont          restart capture automatically after each completed frame
//   ena           sample strobe, one bit per channel per strobe while capturing
//   din           serial data, bit c = channel c
//   dout          held frame, [c*NDATA +: NDATA] = channel c, bit i = sample i
//   dout_valid    dout holds a completed, unconsumed frame
//   dout_ready    consumer accepts dout
//   busy          capture in progress
//   cnt           index of the next sample to be written
//   overrun       sticky: a completed frame was discarded (cleared by start from IDLE)
module multi_input_buff
  import input_buff_defs::*;
#(
  parameter int   NCH       = 4,
  parameter int   NDATA     = 128,
  parameter logic REF_INIT  = 1'b1,
  parameter logic SIG_INIT  = 1'b0,
  localparam int  NDATA_LOG = ndata_log(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cont,
  input  logic                 ena,
  input  logic [NCH-1:0]       din,
  output logic [NCH*NDATA-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic [NDATA_LOG-1:0] cnt,
  output logic                 overrun
);

  localparam logic [NDATA_LOG-1:0] LAST = NDATA_LOG'(NDATA - 1);

  state_t               state;
  logic [NDATA_LOG-1:0] cnt_q;
  logic                 valid_q;
  logic                 overrun_q;

  logic capturing;
  logic sample;
  logic complete;
  logic accept;
  logic load_init;

  assign capturing = (state == CAPTURE);

  // start outranks ena: an aborting start never lets its sample count or
  // complete a frame.
  assign sample   = capturing && ena && !start;
  assign complete = sample && (cnt_q == LAST);

  // Consumer taking the old frame on the same edge frees the hold register.
  assign accept   = complete && (!valid_q || dout_ready);

  // Reload the init pattern whenever a new frame begins: start from any
  // state, or completion (ready for a continuous-mode restart; harmless
  // when returning to IDLE since the next start reloads anyway).
  assign load_init = start || complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CAPTURE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (start) begin
            cnt_q <= '0;
          end else if (ena) begin
            if (cnt_q == LAST) begin
              cnt_q <= '0;
              if (!cont) begin
                state <= IDLE;
              end
              if (valid_q && !dout_ready) begin
                overrun_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt_q <= '0;
        end
      endcase

      // Hold-register handshake is independent of start.
      if (accept) begin
        valid_q <= 1'b1;
      end else if (valid_q && dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_chan
      capture_chan #(
        .NDATA (NDATA),
        .INIT  ((c == 0) ? REF_INIT : SIG_INIT)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .init      (load_init),
        .sample    (sample),
        .idx       (cnt_q),
        .bit_in    (din[c]),
        .load_hold (accept),
        .dout      (dout[c*NDATA +: NDATA])
      );
    end
  endgenerate

  assign busy       = capturing;
  assign cnt        = cnt_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_multi_input_buff.sv
// Directed bench for multi_input_buff with NCH=4, NDATA=8.
// Frames are written as 32-bit words: byte c is channel c, bit i is sample i.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_multi_input_buff;

  localparam int NCH   = 4;
  localparam int NDATA = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont;
  logic        ena;
  logic [3:0]  din;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic [2:0]  cnt;
  logic        overrun;

  int tests  = 0;
  int failed = 0;

  multi_input_buff #(
    .NCH      (NCH),
    .NDATA    (NDATA),
    .REF_INIT (1'b1),
    .SIG_INIT (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .ena        (ena),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .cnt        (cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] F1 = 32'hAAB24D0F; // ch1 = 4D from samples 1,0,1,1,0,0,1,0
  localparam logic [31:0] F2 = 32'h12345678;
  localparam logic [31:0] F3 = 32'hC3A50F96;
  localparam logic [31:0] F4 = 32'h0F0F0F0F;
  localparam logic [31:0] F5 = 32'hDEADBEEF;
  localparam logic [31:0] F6 = 32'h01234567;
  localparam logic [31:0] F7 = 32'h89ABCDEF;
  localparam logic [31:0] F8 = 32'h3C3CA5A5;
  localparam logic [31:0] G  = 32'h5A5A5A5A;
  localparam logic [31:0] RST_PAT = 32'h000000FF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive sample i of frame f onto din.
  task automatic put(input logic [31:0] f, input int i);
    for (int c = 0; c < NCH; c++) begin
      din[c] = f[c*NDATA + i];
    end
  endtask

  // Eight contiguous samples; optionally assert dout_ready only on the final one.
  task automatic frame(input logic [31:0] f, input bit ready_last);
    for (int i = 0; i < NDATA; i++) begin
      put(f, i);
      ena        = 1'b1;
      dout_ready = ready_last && (i == NDATA - 1);
      cyc();
    end
    ena        = 1'b0;
    dout_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    cont       = 1'b0;
    ena        = 1'b0;
    din        = '0;
    dout_ready = 1'b0;

    // Reset state
    cyc();
    cyc();
    check("rst_dout", dout, RST_PAT);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    cyc();
    check("idle_no_start_busy", 32'(busy), 32'd0);

    // Single contiguous frame
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("a_busy", 32'(busy), 32'd1);
    check("a_cnt0", 32'(cnt), 32'd0);
    for (int i = 0; i < NDATA - 1; i++) begin
      put(F1, i);
      ena = 1'b1;
      cyc();
    end
    check("a_cnt7", 32'(cnt), 32'd7);
    check("a_valid_early", 32'(dout_valid), 32'd0);
    put(F1, NDATA - 1);
    cyc();
    ena = 1'b0;
    check("a_valid", 32'(dout_valid), 32'd1);
    check("a_dout", dout, F1);
    check("a_ch1", 32'(dout[15:8]), 32'h4D);
    check("a_busy_done", 32'(busy), 32'd0);
    check("a_cnt_done", 32'(cnt), 32'd0);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    check("a_consumed", 32'(dout_valid), 32'd0);
    check("a_dout_held", dout, F1);

    // Gapped ena: cnt holds across gaps, frame matches contiguous capture
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < NDATA; i++) begin
      put(F2, i);
      ena = 1'b1;
      cyc();
      ena = 1'b0;
      if (i < NDATA - 1) begin
        din = 4'($urandom);
        cyc();
        din = 4'($urandom);
        cyc();
        check("b_gap_cnt", 32'(cnt), 32'(i + 1));
      end
    end
    check("b_valid", 32'(dout_valid), 32'd1);
    check("b_dout", dout, F2);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;

    // Continuous mode with a stalled consumer: second frame dropped
    cont  = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    frame(F3, 1'b0);
    check("c_f3_dout", dout, F3);
    check("c_f3_valid", 32'(dout_valid), 32'd1);
    check("c_f3_busy", 32'(busy), 32'd1);
    check("c_f3_overrun", 32'(overrun), 32'd0);
    frame(F4, 1'b0);
    check("c_f4_kept_first", dout, F3);
    check("c_f4_overrun", 32'(overrun), 32'd1);
    check("c_f4_busy", 32'(busy), 32'd1);
    check("c_f4_valid", 32'(dout_valid), 32'd1);

    // Completion with simultaneous accept replaces the frame; overrun is sticky
    cont = 1'b0;
    frame(F5, 1'b1);
    check("c_f5_dout", dout, F5);
    check("c_f5_valid", 32'(dout_valid), 32'd1);
    check("c_f5_busy", 32'(busy), 32'd0);
    check("c_f5_overrun_sticky", 32'(overrun), 32'd1);

    // Start from IDLE clears overrun; pending frame survives the start
    cont  = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("c_start_overrun_clr", 32'(overrun), 32'd0);
    check("c_start_pending", 32'(dout_valid), 32'd1);
    check("c_start_dout", dout, F5);
    frame(F6, 1'b1);
    check("c_f6_dout", dout, F6);
    check("c_f6_valid", 32'(dout_valid), 32'd1);
    check("c_f6_overrun", 32'(overrun), 32'd0);
    frame(F7, 1'b1);
    check("c_f7_dout", dout, F7);
    check("c_f7_valid", 32'(dout_valid), 32'd1);
    check("c_f7_overrun", 32'(overrun), 32'd0);
    check("c_f7_busy", 32'(busy), 32'd1);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    cont       = 1'b0;
    check("c_consumed", 32'(dout_valid), 32'd0);

    // Abort at cnt=5, then a full fresh frame
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(G, i);
      ena = 1'b1;
      cyc();
    end
    ena = 1'b0;
    check("d_cnt5", 32'(cnt), 32'd5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("d_abort_cnt", 32'(cnt), 32'd0);
    check("d_abort_busy", 32'(busy), 32'd1);
    frame(F8, 1'b0);
    check("d_f8_dout", dout, F8);
    check("d_f8_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;

    // Start coinciding with the final sample: no frame delivered
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < NDATA - 1; i++) begin
      put(G, i);
      ena = 1'b1;
      cyc();
    end
    put(G, NDATA - 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    ena   = 1'b0;
    check("d_collide_valid", 32'(dout_valid), 32'd0);
    check("d_collide_cnt", 32'(cnt), 32'd0);
    check("d_collide_busy", 32'(busy), 32'd1);
    check("d_collide_dout", dout, F8);
    cyc();
    check("d_collide_valid2", 32'(dout_valid), 32'd0);

    // Asynchronous reset mid-capture at cnt=4
    for (int i = 0; i < 4; i++) begin
      put(G, i);
      ena = 1'b1;
      cyc();
    end
    check("e_cnt4", 32'(cnt), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    check("e_async_cnt", 32'(cnt), 32'd0);
    check("e_async_busy", 32'(busy), 32'd0);
    check("e_async_dout", dout, RST_PAT);
    check("e_async_valid", 32'(dout_valid), 32'd0);
    check("e_async_overrun", 32'(overrun), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int i = 0; i < NDATA; i++) begin
      put(G, i);
      ena = 1'b1;
      cyc();
    end
    ena = 1'b0;
    cyc();
    check("e_post_valid", 32'(dout_valid), 32'd0);
    check("e_post_busy", 32'(busy), 32'd0);
    check("e_post_cnt", 32'(cnt), 32'd0);
    check("e_post_dout", dout, RST_PAT);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multi_input_buff.md
MULTI_INPUT_BUFF -- requirements
Module: multi_input_buff

Interface
REQ-001 Parameter NCH, default 4: number of serial input channels.
REQ-002 Parameter NDATA, default 128: bits captured per channel per frame; NDATA_LOG = ceil(log2(NDATA)); NDATA >= 2.
REQ-003 Parameter REF_INIT, default 1'b1: initial value of every bit of channel 0 (reference) at reset and at each frame start.
REQ-004 Parameter SIG_INIT, default 1'b0: initial value of every bit of channels 1..NCH-1 at reset and at each frame start.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  begin a new frame capture (single-cycle pulse).
REQ-008 cont  in  1  continuous mode: on frame completion, restart capture automatically.
REQ-009 ena  in  1  sample strobe: one bit per channel taken on each cycle with ena=1 while capturing.
REQ-010 din  in  NCH  serial data; bit c is channel c.
REQ-011 dout  out  NCH*NDATA  held frame; bits [c*NDATA +: NDATA] belong to channel c; bit index i equals sample number i.
REQ-012 dout_valid  out  1  dout holds a completed, unconsumed frame.
REQ-013 dout_ready  in  1  consumer accepts dout when dout_valid=1.
REQ-014 busy  out  1  capture in progress.
REQ-015 cnt  out  NDATA_LOG  index of the next sample to be written.
REQ-016 overrun  out  1  sticky: a completed frame was discarded.

Function
REQ-017 FSM states: IDLE, CAPTURE; reset state IDLE; busy=1 exactly in CAPTURE.
REQ-018 IDLE + start -> CAPTURE; cnt<=0; capture register loaded with REF_INIT/SIG_INIT pattern; overrun<=0.
REQ-019 CAPTURE + ena: capture bit [cnt] of channel c <= din[c] for all c; cnt<=cnt+1.
REQ-020 CAPTURE + !ena: no capture-register or cnt change.
REQ-021 Frame completion = CAPTURE & ena & cnt==NDATA-1; on that edge the full frame, including the final sample, is offered to the hold register.
REQ-022 On completion: if dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle, hold register <= frame and dout_valid<=1 (one-cycle latency from final sample to dout_valid).
REQ-023 On completion with dout_valid=1 and dout_ready=0: frame discarded, dout unchanged, overrun<=1.
REQ-024 After completion: cont=1 -> remain CAPTURE with cnt<=0 and init pattern reloaded; cont=0 -> IDLE with cnt<=0.
REQ-025 dout_valid & dout_ready without simultaneous completion -> dout_valid<=0, dout holds last value.
REQ-026 start while in CAPTURE aborts the current frame: cnt<=0, init pattern reloaded, stays CAPTURE; start has priority over ena/completion in the same cycle (no hold-register load).
REQ-027 Hold register and dout_valid are independent of start; a pending frame survives a restart.
REQ-028 cnt never exceeds NDATA-1; it wraps to 0 only via REQ-024/REQ-026.

Reset
REQ-029 While rst=0: state IDLE, cnt=0, busy=0, dout_valid=0, overrun=0, capture and hold registers = channel 0 all REF_INIT, others all SIG_INIT (dout shows this pattern).
REQ-030 Reset asserted mid-capture discards the partial frame with no dout_valid pulse; first edge after release behaves as IDLE.

Structure
REQ-031 Shared package/header input_buff_defs holds FSM state encoding and the NDATA_LOG helper.
REQ-032 One sub-module capture_chan (parameters NDATA, INIT) SHALL implement one channel's capture and hold registers, instantiated NCH times via generate; the FSM, cnt and handshake live in multi_input_buff.

Verification (bench NCH=4, NDATA=8)
REQ-033 Reset, no start -> dout[7:0]=8'hFF, dout[31:8]=0, dout_valid=0, busy=0.
REQ-034 start, 8 ena cycles, din[1] pattern 1,0,1,1,0,0,1,0 -> dout[15:8]=8'h4D, dout_valid=1 one cycle after last sample, busy=0.
REQ-035 ena gapped (1,0,0,1,...) across 8 samples -> same frame as contiguous; cnt holds during gaps.
REQ-036 cont=1, dout_ready=0, two frames -> first frame kept, overrun=1, busy=1; cont=1, dout_ready=1 -> back-to-back frames, dout_valid stays 1, no overrun.
REQ-037 start at cnt=5 -> cnt=0, next frame built from fresh samples only; start coinciding with final sample -> no dout_valid.
REQ-038 rst low at cnt=4 -> all outputs at reset values asynchronously, no dout_valid after release.
